// File: rtl/chip8_regmem_xfer.sv
// CHIP-8 FX55/FX65/FX33 register<->memory transfer engine.
// Optional macro CHIP8_I_INCREMENT_EN: store/load write I+X+1 back to I in the DONE cycle.
module chip8_regmem_xfer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [3:0]        x,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              busy,
    output logic              done,
    output logic              i_update,
    output logic [ADDR_W-1:0] i_next,
    output logic [3:0]        reg_rd_idx,
    input  logic [7:0]        reg_rd_data,
    output logic              reg_wr,
    output logic [3:0]        reg_wr_idx,
    output logic [7:0]        reg_wr_data,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [7:0]        mem_read_data,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [7:0]        mem_write_data
);

    typedef enum logic [2:0] {IDLE, STORE, LOAD, BCD, DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        k_q, k_d;
    logic [3:0]        x_q, x_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [7:0]        v_q, v_d;

    // Hold registers keep address/data outputs stable while their strobe is low.
    logic [3:0]        rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]        rw_idx_q, rw_idx_d;
    logic [7:0]        rw_data_q, rw_data_d;

    logic              we, re, rw, rd_act;
    logic [3:0]        rd_idx_live;
    logic [7:0]        wdata_live;
    logic [ADDR_W-1:0] addr_k;

    assign addr_k = i_q + ADDR_W'(k_q);

`ifdef CHIP8_I_INCREMENT_EN
    logic [1:0] op_q, op_d;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        i_d         = i_q;
        v_d         = v_q;
        we          = 1'b0;
        re          = 1'b0;
        rw          = 1'b0;
        rd_act      = 1'b0;
        rd_idx_live = k_q[3:0];
        wdata_live  = reg_rd_data;
`ifdef CHIP8_I_INCREMENT_EN
        op_d        = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d = x;
                    i_d = i_addr;
                    k_d = '0;
`ifdef CHIP8_I_INCREMENT_EN
                    op_d = op;
`endif
                    case (op)
                        2'd0:    state_d = STORE;
                        2'd1:    state_d = LOAD;
                        2'd2:    state_d = BCD;
                        default: state_d = DONE;
                    endcase
                end
            end
            STORE: begin
                we     = 1'b1;
                rd_act = 1'b1;
                if (k_q == {1'b0, x_q}) state_d = DONE;
                else                    k_d = k_q + 5'd1;
            end
            LOAD: begin
                // Read of I+k returns next cycle, so the write lags one step behind.
                re = (k_q <= {1'b0, x_q});
                rw = (k_q != 5'd0);
                if (k_q == {1'b0, x_q} + 5'd1) state_d = DONE;
                else                           k_d = k_q + 5'd1;
            end
            BCD: begin
                we          = 1'b1;
                rd_act      = 1'b1;
                rd_idx_live = x_q;
                case (k_q)
                    5'd0: begin
                        v_d        = reg_rd_data;
                        wdata_live = reg_rd_data / 8'd100;
                    end
                    5'd1:    wdata_live = (v_q / 8'd10) % 8'd10;
                    default: wdata_live = v_q % 8'd10;
                endcase
                if (k_q == 5'd2) state_d = DONE;
                else             k_d = k_q + 5'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_idx_d  = rd_act ? rd_idx_live : rd_idx_q;
    assign wr_addr_d = we ? addr_k : wr_addr_q;
    assign wr_data_d = we ? wdata_live : wr_data_q;
    assign rd_addr_d = re ? addr_k : rd_addr_q;
    assign rw_idx_d  = rw ? (k_q[3:0] - 4'd1) : rw_idx_q;
    assign rw_data_d = rw ? mem_read_data : rw_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            x_q       <= '0;
            i_q       <= '0;
            v_q       <= '0;
            rd_idx_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rw_idx_q  <= '0;
            rw_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            x_q       <= x_d;
            i_q       <= i_d;
            v_q       <= v_d;
            rd_idx_q  <= rd_idx_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rw_idx_q  <= rw_idx_d;
            rw_data_q <= rw_data_d;
        end
    end

    assign busy           = (state_q == STORE) || (state_q == LOAD) || (state_q == BCD);
    assign done           = (state_q == DONE);
    assign mem_write      = we;
    assign mem_read       = re;
    assign reg_wr         = rw;
    assign reg_rd_idx     = rd_idx_d;
    assign mem_write_addr = wr_addr_d;
    assign mem_write_data = wr_data_d;
    assign mem_read_addr  = rd_addr_d;
    assign reg_wr_idx     = rw_idx_d;
    assign reg_wr_data    = rw_data_d;

`ifdef CHIP8_I_INCREMENT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_q <= '0;
        else        op_q <= op_d;
    end

    assign i_update = (state_q == DONE) && ((op_q == 2'd0) || (op_q == 2'd1));
    assign i_next   = i_update ? (i_q + ADDR_W'(x_q) + ADDR_W'(1)) : '0;
`else
    assign i_update = 1'b0;
    assign i_next   = '0;
`endif

endmodule

// File: tb/tb_chip8_regmem_xfer.sv
// Directed bench for chip8_regmem_xfer with a byte memory and V-register model.
module tb_chip8_regmem_xfer;

    localparam int ADDR_W = 12;
`ifdef CHIP8_I_INCREMENT_EN
    localparam bit INC = 1'b1;
`else
    localparam bit INC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        op = '0;
    logic [3:0]        x = '0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              busy, done, i_update;
    logic [ADDR_W-1:0] i_next;
    logic [3:0]        reg_rd_idx, reg_wr_idx;
    logic [7:0]        reg_rd_data, reg_wr_data;
    logic              reg_wr, mem_read, mem_write;
    logic [ADDR_W-1:0] mem_read_addr, mem_write_addr;
    logic [7:0]        mem_read_data, mem_write_data;

    logic [7:0] mem [0:4095];
    logic [7:0] vreg [0:15];
    logic [7:0] rdata_q;
    logic              pk_mem = 1'b0, pk_reg = 1'b0;
    logic [ADDR_W-1:0] pk_addr = '0;
    logic [7:0]        pk_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chip8_regmem_xfer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .i_addr(i_addr),
        .busy(busy), .done(done), .i_update(i_update), .i_next(i_next),
        .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data), .reg_wr(reg_wr),
        .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    assign reg_rd_data   = vreg[reg_rd_idx];
    assign mem_read_data = rdata_q;

    always @(posedge clk) begin
        if (mem_write) mem[mem_write_addr] <= mem_write_data;
        if (mem_read)  rdata_q <= mem[mem_read_addr];
        if (reg_wr)    vreg[reg_wr_idx] <= reg_wr_data;
        if (pk_mem)    mem[pk_addr] <= pk_data;
        if (pk_reg)    vreg[pk_addr[3:0]] <= pk_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_mem(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        pk_mem = 1'b1; pk_addr = a; pk_data = d;
        tick();
        pk_mem = 1'b0;
    endtask

    task automatic poke_reg(input logic [3:0] idx, input logic [7:0] d);
        pk_reg = 1'b1; pk_addr = ADDR_W'(idx); pk_data = d;
        tick();
        pk_reg = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] o, input logic [3:0] xx, input logic [ADDR_W-1:0] ia);
        start = 1'b1; op = o; x = xx; i_addr = ia;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] sdat [0:3];
        logic [7:0] ldat [0:2];
        logic [7:0] bdat [0:2];

        // reset state
        #2;
        chk("rst_strobes", {busy, done, i_update, reg_wr, mem_read, mem_write}, 64'd0);
        chk("rst_addr", {i_next, mem_read_addr, mem_write_addr}, 64'd0);
        chk("rst_data", {reg_rd_idx, reg_wr_idx, reg_wr_data, mem_write_data}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // store X=3, I=0x300
        sdat[0] = 8'h11; sdat[1] = 8'h22; sdat[2] = 8'h33; sdat[3] = 8'h44;
        for (int i = 0; i < 4; i++) poke_reg(4'(i), sdat[i]);
        poke_reg(4'd4, 8'h99);
        poke_mem(12'h304, 8'hEE);
        start_cmd(2'd0, 4'd3, 12'h300);
        for (int k = 0; k < 4; k++) begin
            chk("st_busy", {busy, done, mem_write, mem_read, reg_wr}, 64'b10100);
            chk("st_addr", mem_write_addr, 64'(12'h300 + k));
            chk("st_data", mem_write_data, 64'(sdat[k]));
            tick();
        end
        chk("st_done", {busy, done, mem_write}, 64'b010);
        chk("st_addr_hold", mem_write_addr, 64'h303);
        chk("st_iupd", {i_update, i_next}, INC ? {1'b1, 12'h304} : 13'd0);
        tick();
        chk("st_done_pulse", done, 64'd0);
        chk("st_mem303", mem[12'h303], 64'h44);
        chk("st_mem304", mem[12'h304], 64'hEE);

        // load X=2, I=0x200
        ldat[0] = 8'hA1; ldat[1] = 8'hB2; ldat[2] = 8'hC3;
        for (int i = 0; i < 3; i++) poke_mem(12'(12'h200 + i), ldat[i]);
        poke_reg(4'd3, 8'h77);
        start_cmd(2'd1, 4'd2, 12'h200);
        for (int k = 0; k < 4; k++) begin
            chk("ld_strobes", {busy, done, mem_write, mem_read, reg_wr},
                {3'b100, 1'(k <= 2), 1'(k >= 1)});
            if (k <= 2) chk("ld_raddr", mem_read_addr, 64'(12'h200 + k));
            if (k >= 1) begin
                chk("ld_widx", reg_wr_idx, 64'(k - 1));
                chk("ld_wdata", reg_wr_data, 64'(ldat[k-1]));
            end
            tick();
        end
        chk("ld_done", {busy, done, reg_wr, mem_read}, 64'b0100);
        chk("ld_iupd", {i_update, i_next}, INC ? {1'b1, 12'h203} : 13'd0);
        tick();
        chk("ld_v0v1v2", {vreg[0], vreg[1], vreg[2]}, 64'hA1B2C3);
        chk("ld_v3", vreg[3], 64'h77);

        // BCD of 254; V7 changed mid-command to prove the value is latched
        poke_reg(4'd7, 8'hFE);
        bdat[0] = 8'd2; bdat[1] = 8'd5; bdat[2] = 8'd4;
        start_cmd(2'd2, 4'd7, 12'h400);
        for (int k = 0; k < 3; k++) begin
            chk("bcd_strobes", {busy, mem_write, mem_read, reg_wr}, 64'b1100);
            chk("bcd_ridx", reg_rd_idx, 64'd7);
            chk("bcd_addr", mem_write_addr, 64'(12'h400 + k));
            chk("bcd_data", mem_write_data, 64'(bdat[k]));
            if (k == 0) poke_reg(4'd7, 8'h05);
            else        tick();
        end
        chk("bcd_done", {busy, done, i_update}, 64'b010);
        tick();
        chk("bcd_mem", {mem[12'h400], mem[12'h401], mem[12'h402]}, 64'h020504);

        // BCD of 5
        start_cmd(2'd2, 4'd7, 12'h410);
        tick(); tick(); tick();
        chk("bcd5_done", done, 64'd1);
        tick();
        chk("bcd5_mem", {mem[12'h410], mem[12'h411], mem[12'h412]}, 64'h000005);

        // store with address wrap
        poke_reg(4'd0, 8'h5A);
        poke_reg(4'd1, 8'hA5);
        start_cmd(2'd0, 4'd1, 12'hFFF);
        chk("wr_addr0", mem_write_addr, 64'hFFF);
        tick();
        chk("wr_addr1", mem_write_addr, 64'h000);
        tick();
        chk("wr_done", done, 64'd1);
        chk("wr_iupd", {i_update, i_next}, INC ? {1'b1, 12'h001} : 13'd0);
        tick();
        chk("wr_mem", {mem[12'hFFF], mem[12'h000]}, 64'h5AA5);

        // reset during a X=15 load
        for (int i = 2; i < 16; i++) poke_reg(4'(i), 8'h3C);
        for (int i = 0; i < 16; i++) poke_mem(12'(12'h500 + i), 8'(8'h80 + i));
        start_cmd(2'd1, 4'd15, 12'h500);
        tick(); tick();
        chk("rm_pre", {busy, reg_wr, mem_read}, 64'b111);
        rst_n = 1'b0;
        #1;
        chk("rm_strobes", {busy, done, i_update, reg_wr, mem_read, mem_write}, 64'd0);
        chk("rm_addr", {i_next, mem_read_addr, mem_write_addr}, 64'd0);
        chk("rm_data", {reg_rd_idx, reg_wr_idx, reg_wr_data, mem_write_data}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rm_no_done", {done, busy}, 64'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("rm_regs", {vreg[0], vreg[1], vreg[2], vreg[15]}, 64'h80A53C3C);
        start_cmd(2'd0, 4'd0, 12'h600);
        chk("rm_new_wr", {mem_write, mem_write_addr, mem_write_data}, {1'b1, 12'h600, 8'h80});
        tick();
        chk("rm_new_done", done, 64'd1);
        tick();

        // start ignored while busy and in DONE; op=3 from IDLE
        start_cmd(2'd0, 4'd1, 12'h700);
        start = 1'b1; op = 2'd3;
        tick();
        start = 1'b0;
        chk("ign_busy", {busy, mem_write, mem_write_addr, mem_write_data}, {2'b11, 12'h701, 8'hA5});
        tick();
        chk("ign_done", done, 64'd1);
        start = 1'b1; op = 2'd3;
        tick();
        start = 1'b0;
        chk("ign_in_done", {done, busy}, 64'd0);
        chk("ign_mem", {mem[12'h700], mem[12'h701]}, 64'h80A5);
        start_cmd(2'd3, 4'd5, 12'h123);
        chk("rsv_done", {done, busy, i_update, mem_read, mem_write, reg_wr}, 64'b100000);
        tick();
        chk("rsv_after", {done, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
